uart_tx_fifo: RTL and testbench

//  Buffered 8N1 UART transmitter with a write-side FIFO. Host logic (e.g. the ZX81

---
 rtl/uart_tx_fifo_if.sv | 21 ++
 rtl/uart_tx_fifo.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle for uart_tx_fifo: host pushes bytes,
// block reports occupancy and activity.
interface uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
);
  logic [7:0]       wr_data;
  logic             wr_en;
  logic             full;
  logic [FIFO_AW:0] fifo_count;
  logic             busy;

  modport master (
    output wr_data, wr_en,
    input  full, fifo_count, busy
  );

  modport slave (
    input  wr_data, wr_en,
    output full, fifo_count, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO in front of an
// LSB-first serialiser running off a per-bit baud counter.
module uart_tx_fifo #(
  parameter int BIT_PERIOD = 434,
  parameter int FIFO_AW    = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic          clock,
  input  logic          reset,
  uart_tx_fifo_if.slave wr_if,
  output logic          dce_txd
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = FIFO_AW + 1;

  localparam logic [9:0] BAUD_LAST = 10'(BIT_PERIOD - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [9:0]         baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;

  logic full;
  logic push;
  logic pop;
  logic wrap;

  assign full = (cnt_q == CNT_FULL);
  assign push = wr_if.wr_en && !full;
  assign wrap = (baud_q == BAUD_LAST);

  assign wr_if.full       = full;
  assign wr_if.fifo_count = cnt_q;
  assign wr_if.busy       = busy_q;
  assign dce_txd          = txd_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        baud_d = wrap ? '0 : baud_q + 10'd1;
        if (wrap) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = wrap ? '0 : baud_q + 10'd1;
        if (wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        baud_d = wrap ? '0 : baud_q + 10'd1;
        if (wrap) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            // chain straight into the next start bit
            if (cnt_q != '0) begin
              pop     = 1'b1;
              shift_d = mem_q[rd_ptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    busy_d = (state_d != IDLE) || (cnt_d != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= wr_if.wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue plus
// frame-timer reference model; second instance uses 2 stop bits.
module tb_uart_tx_fifo;

  localparam int BP    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd1;
  logic txd2;

  uart_tx_fifo_if #(.FIFO_AW(AW)) w1 ();
  uart_tx_fifo_if #(.FIFO_AW(AW)) w2 ();

  uart_tx_fifo #(
    .BIT_PERIOD(BP),
    .FIFO_AW   (AW),
    .STOP_BITS (1)
  ) u_dut (
    .clock  (clk),
    .reset  (rst),
    .wr_if  (w1),
    .dce_txd(txd1)
  );

  uart_tx_fifo #(
    .BIT_PERIOD(BP),
    .FIFO_AW   (AW),
    .STOP_BITS (2)
  ) u_dut2 (
    .clock  (clk),
    .reset  (rst),
    .wr_if  (w2),
    .dce_txd(txd2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mq[$];
  int         remain = 0;
  logic [7:0] cur = 8'h00;
  logic       exp_txd = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: queue of accepted bytes plus cycles left in current frame.
  task automatic step();
    int   k;
    int   b;
    logic nt;
    logic acc;
    logic popn;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      remain  = 0;
      exp_txd = 1'b1;
    end else begin
      nt = 1'b1;
      if (remain != 0) begin
        k = FRAME - remain;
        b = k / BP;
        if (b == 0) nt = 1'b0;
        else if (b <= 8) nt = cur[b-1];
      end
      acc  = w1.wr_en && (mq.size() < DEPTH);
      popn = (mq.size() != 0) && (remain <= 1);
      if (popn) begin
        cur    = mq.pop_front();
        remain = FRAME;
      end else if (remain > 0) begin
        remain--;
      end
      if (acc) mq.push_back(w1.wr_data);
      exp_txd = nt;
    end
    @(negedge clk);
    chk("txd", 32'(txd1), 32'(exp_txd));
    chk("count", 32'(w1.fifo_count), 32'(mq.size()));
    chk("full", 32'(w1.full), 32'(mq.size() == DEPTH));
    chk("busy", 32'(w1.busy), 32'(remain != 0 || mq.size() != 0));
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push1(input logic [7:0] d);
    w1.wr_en   = 1'b1;
    w1.wr_data = d;
    step();
    w1.wr_en   = 1'b0;
    w1.wr_data = 8'($urandom);
  endtask

  initial begin
    int n;
    int lo;
    int hi;
    w1.wr_en   = 1'b0;
    w1.wr_data = 8'h00;
    w2.wr_en   = 1'b0;
    w2.wr_data = 8'h00;
    rst = 1'b1;
    step();
    step();
    chk("rst_txd", 32'(txd1), 32'd1);
    chk("rst_cnt", 32'(w1.fifo_count), 32'd0);
    rst = 1'b0;
    idle(3);

    push1(8'h55);
    idle(FRAME + 10);

    push1(8'hA3);
    push1(8'h0F);
    idle(2 * FRAME + 10);

    for (int i = 0; i < 6; i++) push1(8'($urandom));
    idle(5 * FRAME + 10);

    push1(8'hFF);
    push1(8'hFF);
    push1(8'hFF);
    n = 0;
    while (remain != FRAME - (4 * BP + 3) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("t4_wait", 32'(n < 2 * FRAME), 32'd1);
    rst = 1'b1;
    w1.wr_en = 1'b1;
    step();
    rst = 1'b0;
    w1.wr_en = 1'b0;
    chk("t4_cnt", 32'(w1.fifo_count), 32'd0);
    chk("t4_txd", 32'(txd1), 32'd1);
    chk("t4_busy", 32'(w1.busy), 32'd0);
    idle(2 * FRAME);

    for (int i = 0; i < 5; i++) push1(8'($urandom));
    n = 0;
    while (!(remain == 1 && mq.size() != 0) && n < 2 * FRAME) begin
      step();
      n++;
    end
    chk("t6_wait", 32'(n < 2 * FRAME), 32'd1);
    chk("t6_pre", 32'(w1.fifo_count), 32'd4);
    push1(8'hC3);
    chk("t6_cnt", 32'(w1.fifo_count), 32'd3);
    idle(4 * FRAME + 10);

    for (int c = 0; c < 4000; c++) begin
      rst        = ($urandom_range(0, 599) == 0);
      w1.wr_en   = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 3 : 40));
      w1.wr_data = 8'($urandom);
      step();
    end
    rst      = 1'b0;
    w1.wr_en = 1'b0;
    idle((DEPTH + 1) * FRAME + 10);
    chk("end_busy", 32'(w1.busy), 32'd0);

    w2.wr_en   = 1'b1;
    w2.wr_data = 8'h00;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    w2.wr_en = 1'b0;
    @(negedge clk);
    n = 0;
    while (txd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start", 32'(txd2), 32'd0);
    lo = 0;
    while (!txd2 && lo < 200) begin
      lo++;
      @(negedge clk);
    end
    chk("t5_low", 32'(lo), 32'd72);
    hi = 0;
    while (txd2 && hi < 200) begin
      hi++;
      @(negedge clk);
    end
    chk("t5_high", 32'(hi), 32'd16);
    repeat (120) @(negedge clk);
    chk("t5_busy", 32'(w2.busy), 32'd0);
    chk("t5_idle", 32'(txd2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
